// File: rtl/ro_race_counter.sv
// rtl/ro_race_counter.sv - ring-oscillator race edge counter feeding the race arbiter
// Optional cycle-limit abort is built when RACE_TIMEOUT_EN is defined.
module ro_race_counter #(
  parameter int CNT_W          = 16,
  parameter int THRESHOLD      = 1000,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ro1,
  input  logic             ro2,
  output logic             ro_en,
  output logic             finished1,
  output logic             finished2,
  output logic             tie,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync1, sync2;
  logic                   hist1, hist2;
  logic                   armed;
  logic                   synced1, synced2;
  logic                   rise1, rise2;
  logic                   hit1, hit2;
  logic                   to_hit;

  assign synced1 = sync1[SYNC_STAGES-1];
  assign synced2 = sync2[SYNC_STAGES-1];
  // armed stays low for the first RUN sample so a level already high is not an edge
  assign rise1   = armed & synced1 & ~hist1;
  assign rise2   = armed & synced2 & ~hist2;
  assign hit1    = (count1 == THR);
  assign hit2    = (count2 == THR);

`ifdef RACE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cyc;

  assign to_hit = (cyc == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= '0;
    end else if (state_q != RUN) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end
`else
  // RUN never times out in this build
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], ro1};
      sync2 <= {sync2[SYNC_STAGES-2:0], ro2};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (hit1 || hit2 || to_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count1    <= '0;
      count2    <= '0;
      finished1 <= 1'b0;
      finished2 <= 1'b0;
      tie       <= 1'b0;
      timeout   <= 1'b0;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      hist1     <= 1'b0;
      hist2     <= 1'b0;
      armed     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            count1    <= '0;
            count2    <= '0;
            finished1 <= 1'b0;
            finished2 <= 1'b0;
            tie       <= 1'b0;
            timeout   <= 1'b0;
            hist1     <= 1'b0;
            hist2     <= 1'b0;
            armed     <= 1'b0;
            ro_en     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          hist1 <= synced1;
          hist2 <= synced2;
          armed <= 1'b1;
          if (rise1 && !hit1) count1 <= count1 + 1'b1;
          if (rise2 && !hit2) count2 <= count2 + 1'b1;
          // a finish landing with the timeout takes priority
          if (hit1 || hit2) begin
            finished1 <= hit1;
            finished2 <= hit2;
            tie       <= hit1 & hit2;
            ro_en     <= 1'b0;
            busy      <= 1'b0;
          end else if (to_hit) begin
            timeout <= 1'b1;
            ro_en   <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_race_counter.sv
// tb/tb_ro_race_counter.sv - randomized and directed races against a closed-form race model
module tb_ro_race_counter;
  localparam int TH    = 8;
  localparam int SS    = 2;
  localparam int TO    = 50;
  localparam int LIMIT = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, ro1 = 1'b0, ro2 = 1'b0;
  logic        ro_en, finished1, finished2, tie, busy, timeout;
  logic [15:0] count1, count2;

  logic        b_start = 1'b0, b_ro1 = 1'b0, b_ro2 = 1'b0;
  logic        b_ro_en, b_finished1, b_finished2, b_tie, b_busy, b_timeout;
  logic [15:0] b_count1, b_count2;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  ro_race_counter #(.CNT_W(16), .THRESHOLD(TH), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .ro1(ro1), .ro2(ro2),
    .ro_en(ro_en), .finished1(finished1), .finished2(finished2), .tie(tie),
    .busy(busy), .timeout(timeout), .count1(count1), .count2(count2));

  ro_race_counter #(.CNT_W(16), .THRESHOLD(1), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .ro1(b_ro1), .ro2(b_ro2),
    .ro_en(b_ro_en), .finished1(b_finished1), .finished2(b_finished2), .tie(b_tie),
    .busy(b_busy), .timeout(b_timeout), .count1(b_count1), .count2(b_count2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Oscillator level at drive slot k: period per, high for per/2 slots, first rise at slot p.
  function automatic logic wave(input int k, input int p, input int per);
    return (k >= p) && (((k - p) % per) < (per / 2));
  endfunction

  // Rises at slots p, p+per, ... each land in the count SS+1 edges later; saturates at TH.
  function automatic int exp_cnt(input int m, input int p, input int per);
    int c;
    if (m - (SS + 1) - p < 0) return 0;
    c = (m - (SS + 1) - p) / per + 1;
    return (c > TH) ? TH : c;
  endfunction

  task automatic run_race(input int p1, input int per1, input int p2, input int per2,
                          input int restart_at, input int abort_at);
    int  k1, k2, kend, mm;
    bit  tmo;
    k1   = p1 + (TH - 1) * per1 + SS + 2;
    k2   = p2 + (TH - 1) * per2 + SS + 2;
    kend = (k1 < k2) ? k1 : k2;
    tmo  = 1'b0;
`ifdef RACE_TIMEOUT_EN
    if (kend > TO) begin
      kend = TO;
      tmo  = 1'b1;
    end
`endif
    ro1 = 1'b0;
    ro2 = 1'b0;
    repeat (SS + 2) @(negedge clk);
    start = 1'b1;
    for (int m = 1; m <= LIMIT; m++) begin
      @(negedge clk);
      start = (m - 1 == restart_at);
      ro1   = wave(m - 1, p1, per1);
      ro2   = wave(m - 1, p2, per2);
      @(posedge clk);
      #1;
      mm = (m < kend) ? m : kend;
      check("count1", count1, exp_cnt(mm, p1, per1));
      check("count2", count2, exp_cnt(mm, p2, per2));
      if (m == abort_at) begin
        #1 reset = 1'b1;
        #1;
        check("abort_count1", count1, 0);
        check("abort_count2", count2, 0);
        check("abort_busy", busy, 0);
        check("abort_ro_en", ro_en, 0);
        check("abort_finished1", finished1, 0);
        check("abort_tie", tie, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = m; k < m + 40; k++) begin
          @(negedge clk);
          ro1 = wave(k, p1, per1);
          ro2 = wave(k, p2, per2);
        end
        @(posedge clk);
        #1;
        check("post_abort_finished1", finished1, 0);
        check("post_abort_busy", busy, 0);
        check("post_abort_count1", count1, 0);
        return;
      end
      if (m < kend) begin
        check("busy_run", busy, 1);
        check("ro_en_run", ro_en, 1);
      end else begin
        check("finished1", finished1, (!tmo && k1 == kend));
        check("finished2", finished2, (!tmo && k2 == kend));
        check("tie", tie, (!tmo && k1 == kend && k2 == kend));
        check("timeout", timeout, tmo);
        check("busy_done", busy, 0);
        check("ro_en_done", ro_en, 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_finished1", finished1, (!tmo && k1 == kend));
        check("hold_count2", count2, exp_cnt(kend, p2, per2));
        break;
      end
    end
    if (kend > LIMIT) begin
      check("busy_no_timeout", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    int per1, per2, n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count1", count1, 0);
    check("rst_finished1", finished1, 0);
    check("rst_busy", busy, 0);
    check("rst_ro_en", ro_en, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b0;

    run_race(0, 10, 5, 14, -1, -1);
    run_race(0, 10, 0, 10, -1, -1);
    run_race(0, 10, 3, 14, -1, 33);
    run_race(0, 12, 0, 6, 20, -1);
    run_race(100000, 10, 100000, 10, -1, -1);
    for (int r = 0; r < 6; r++) begin
      per1 = $urandom_range(4, 16);
      per2 = $urandom_range(4, 16);
      run_race($urandom_range(0, per1 - 1), per1, $urandom_range(0, per2 - 1), per2,
               (r % 2 == 0) ? int'($urandom_range(2, 25)) : -1, -1);
    end

    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (3) @(negedge clk);
    b_ro1 = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b_finished1) begin
        n = k;
        break;
      end
    end
    check("thr1_latency", n, SS + 2);
    check("thr1_count1", b_count1, 1);
    check("thr1_finished2", b_finished2, 0);
    check("thr1_busy", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ro_race_counter.md
Name: ro_race_counter

Overview:
- Upstream stage of the race arbiter.
- Counts rising edges of two free-running ring-oscillator signals during a race window.
- Asserts finished1/finished2 when the respective count reaches THRESHOLD.
- These levels drive the arbiter's finished1/finished2 inputs directly. Also gates the oscillators and reports the raw counts for characterisation.

Parameters:
CNT_W, 16, width of each edge counter and of count1/count2
THRESHOLD, 1000, edge count that ends a race for one oscillator; legal range 1..2^CNT_W-1
SYNC_STAGES, 2, flop stages synchronising each ro input into clk; minimum 2
TIMEOUT_CYCLES, 65535, clk cycles in RUN before timeout fires (used only with RACE_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  one-cycle pulse; begins a race from IDLE or DONE
ro1  input  1  oscillator 1 output, asynchronous to clk
ro2  input  1  oscillator 2 output, asynchronous to clk
ro_en  output  1  oscillator enable; high only in RUN
finished1  output  1  count1 reached THRESHOLD; held until next start
finished2  output  1  count2 reached THRESHOLD; held until next start
tie  output  1  both finished asserted in the same cycle
busy  output  1  high in RUN
timeout  output  1  race aborted by timeout
count1  output  CNT_W  current edge count, oscillator 1
count2  output  CNT_W  current edge count, oscillator 2

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - count1 = count2 = 0.
  - finished1, finished2, tie, timeout, ro_en and busy all go to 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE or DONE with start=1:
  - Next cycle: counts, finished1/2, tie and timeout cleared; the synchroniser edge-detect history is cleared; state goes to RUN.
  - ro_en=1 and busy=1 from that cycle.
- start while in RUN is ignored.
- Edge detection:
  - Each ro input passes through a SYNC_STAGES flop chain, then one history flop.
  - A rising edge is the synced value =1 while the history =0.
  - The first sample after entering RUN does not count as an edge.
  - Latency from an ro edge to the count increment is SYNC_STAGES+1 clk cycles.
  - ro frequency must be below clk/4. Faster inputs undercount; this is not flagged.
- Counters in RUN:
  - count_i increments by 1 per detected edge.
  - A counter never exceeds THRESHOLD.
  - In the cycle count_i reaches THRESHOLD, finished_i is registered high.
- RUN exits to DONE on the cycle either finished becomes high:
  - ro_en=0 and busy=0.
  - Both counts freeze, including the loser's partial count.
- Simultaneous finish: if both counters reach THRESHOLD in the same cycle, finished1=finished2=1 and tie=1. The arbiter's resolution of the tie is not this block's concern.
- DONE holds all outputs until the next start or reset.
- Reset during RUN aborts the race. No finished pulse is produced.
- THRESHOLD=1: finished follows the first counted edge.

Optional Feature:
RACE_TIMEOUT_EN
- Defined:
  - A cycle counter (width ceil(log2(TIMEOUT_CYCLES+1))) clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with neither finished set, the block moves to DONE with timeout=1 and finished1=finished2=0. The downstream done stays low.
  - If a finish and the timeout land in the same cycle, the finish wins and timeout=0.
- Undefined: no cycle counter is built, timeout is tied to 0, and RUN lasts indefinitely.

Test Plan:
- THRESHOLD=8; ro1 period 10 clk, ro2 period 14 clk; pulse start -> finished1=1 first, finished2=0, count1=8, count2=5, ro_en falls the same cycle finished1 rises, tie=0.
- Identical, phase-aligned ro1/ro2, THRESHOLD=8 -> finished1=finished2=1 in the same cycle, tie=1, counts both 8.
- Assert reset for 1 cycle midway through a race (count1=4) -> all outputs 0 immediately, state IDLE, no finished pulse afterwards until a new start.
- After DONE, pulse start again with ro2 faster -> flags clear, new race ends with finished2=1, finished1=0. A start pulsed during RUN is ignored (counts not cleared).
- RACE_TIMEOUT_EN, TIMEOUT_CYCLES=50, ro1/ro2 held low -> at RUN cycle 50, timeout=1, finished1=finished2=0, ro_en=0. Without the macro the same stimulus keeps busy=1 for 200+ cycles.
- THRESHOLD=1, single ro1 edge -> finished1 rises SYNC_STAGES+2 clk cycles after the edge, count1=1.
